// File: rtl/ucie_ctl_sb_arb_pkg.sv
// Shared state encoding, header field layout and credit width for the sideband TX arbiter.
// Header beat: decode in [4:0], source index in [7:5], even parity over [30:0] in bit 31.
package ucie_ctl_sb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        DATA
    } state_t;

    localparam int DEC_LSB     = 0;
    localparam int SRC_LSB     = 5;
    localparam int PAR_BIT     = 31;
    localparam int DEC_W       = 5;
    localparam int SRC_W       = 3;
    localparam int PAYLOAD_BIT = 4;
    localparam int CRD_W       = 4;

    function automatic logic [31:0] hdr_beat(input logic [DEC_W-1:0] dec,
                                             input logic [SRC_W-1:0] src);
        logic [31:0] beat;
        beat                   = '0;
        beat[DEC_LSB +: DEC_W] = dec;
        beat[SRC_LSB +: SRC_W] = src;
        beat[PAR_BIT]          = ^beat[PAR_BIT-1:0];
        return beat;
    endfunction

endpackage

// File: rtl/ucie_ctl_rr_arbiter.sv
// Round-robin one-hot grant: first asserted request at or after ptr_i, wrapping.
// Purely combinational; grant is all-zero when en_i is low or nothing is requested.
module ucie_ctl_rr_arbiter #(
    parameter int N  = 3,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    input  logic          en_i,
    output logic [N-1:0]  gnt_o
);

    logic found;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        for (int j = 0; j < N; j++) begin
            for (int k = 0; k < N; k++) begin
                if (en_i && !found && req_i[k] && (k == ((int'(ptr_i) + j) % N))) begin
                    gnt_o[k] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ucie_ctl_sb_arbiter.sv
// Credit-controlled arbiter sharing the RDI sideband TX channel; header at T+1, payload at T+2.
// Ready is combinational, offered only in IDLE or on a final beat with credit left; UCIE_SB_ARB_ERR_PRIO_EN gives requester 0 priority.
module ucie_ctl_sb_arbiter
    import ucie_ctl_sb_arb_pkg::*;
#(
    parameter int NREQ    = 3,
    parameter int NC      = 32,
    parameter int CRD_MAX = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [NREQ-1:0]   i_req_valid,
    input  logic [5*NREQ-1:0] i_req_decode,
    input  logic [32*NREQ-1:0] i_req_data,
    output logic [NREQ-1:0]   o_req_ready,
    output logic              o_cfg_vld,
    output logic [NC-1:0]     o_cfg,
    input  logic              i_cfg_crd,
    output logic              o_busy,
    output logic [CRD_W-1:0]  o_crd_cnt,
    output logic              o_crd_ovf_err
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t             state_q;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [DEC_W-1:0]   dec_q;
    logic [31:0]        dat_q;
    logic [CRD_W-1:0]   crd_q, crd_d;
    logic               ovf_q, ovf_d;
    logic [NC-1:0]      cfg_q;
    logic               cfg_vld_q;

    logic               last_beat;
    logic               can_grant;
    logic               accept;
    logic [NREQ-1:0]    rr_gnt;
    logic [NREQ-1:0]    gnt;
    logic [SRC_W-1:0]   gnt_idx;
    logic [DEC_W-1:0]   gnt_dec;
    logic [31:0]        gnt_dat;

    // A new grant may overlap the last beat of the current message for back-to-back issue.
    assign last_beat = ((state_q == HDR) && !dec_q[PAYLOAD_BIT]) || (state_q == DATA);
    assign can_grant = !i_rst && ((state_q == IDLE) || last_beat) && (crd_q != '0);

    ucie_ctl_rr_arbiter #(
        .N  (NREQ),
        .PW (PW)
    ) u_rr (
        .req_i (i_req_valid),
        .ptr_i (ptr_q),
        .en_i  (can_grant),
        .gnt_o (rr_gnt)
    );

    always_comb begin
`ifdef UCIE_SB_ARB_ERR_PRIO_EN
        if (can_grant && i_req_valid[0]) begin
            gnt = NREQ'(1);
        end else begin
            gnt = rr_gnt;
        end
`else
        gnt = rr_gnt;
`endif
    end

    assign accept      = |gnt;
    assign o_req_ready = gnt;

    always_comb begin
        gnt_idx = '0;
        gnt_dec = '0;
        gnt_dat = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (gnt[k]) begin
                gnt_idx = SRC_W'(k);
                gnt_dec = i_req_decode[5*k +: 5];
                gnt_dat = i_req_data[32*k +: 32];
            end
        end
    end

    always_comb begin
        int nxt;
        nxt   = int'(gnt_idx) + 1;
        if (nxt >= NREQ) begin
            nxt = 0;
        end
        ptr_d = ptr_q;
        if (accept) begin
`ifdef UCIE_SB_ARB_ERR_PRIO_EN
            if (!gnt[0]) begin
                ptr_d = PW'(nxt);
            end
`else
            ptr_d = PW'(nxt);
`endif
        end
    end

    always_comb begin
        crd_d = crd_q;
        ovf_d = ovf_q;
        if (accept && !i_cfg_crd) begin
            crd_d = crd_q - CRD_W'(1);
        end else if (!accept && i_cfg_crd) begin
            if (crd_q == CRD_W'(CRD_MAX)) begin
                ovf_d = 1'b1;
            end else begin
                crd_d = crd_q + CRD_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            dec_q     <= '0;
            dat_q     <= '0;
            crd_q     <= CRD_W'(CRD_MAX);
            ovf_q     <= 1'b0;
            cfg_q     <= '0;
            cfg_vld_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            crd_q <= crd_d;
            ovf_q <= ovf_d;
            if (accept) begin
                state_q   <= HDR;
                dec_q     <= gnt_dec;
                dat_q     <= gnt_dat;
                cfg_q     <= hdr_beat(gnt_dec, gnt_idx);
                cfg_vld_q <= 1'b1;
            end else if ((state_q == HDR) && dec_q[PAYLOAD_BIT]) begin
                state_q   <= DATA;
                cfg_q     <= dat_q;
                cfg_vld_q <= 1'b1;
            end else if (last_beat) begin
                state_q   <= IDLE;
                cfg_q     <= '0;
                cfg_vld_q <= 1'b0;
            end
        end
    end

    assign o_cfg_vld     = cfg_vld_q;
    assign o_cfg         = cfg_q;
    assign o_busy        = (state_q != IDLE);
    assign o_crd_cnt     = crd_q;
    assign o_crd_ovf_err = ovf_q;

endmodule

// File: tb/tb_ucie_ctl_sb_arbiter.sv
// Directed plus randomized bench for ucie_ctl_sb_arbiter against a beat-queue reference model.
module tb_ucie_ctl_sb_arbiter;

    localparam int NREQ    = 3;
    localparam int CRD_MAX = 4;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   valid;
    logic [4:0]        dec [NREQ];
    logic [31:0]       dat [NREQ];
    logic [5*NREQ-1:0] req_decode;
    logic [32*NREQ-1:0] req_data;
    logic [NREQ-1:0]   o_req_ready;
    logic              o_cfg_vld;
    logic [31:0]       o_cfg;
    logic              crd;
    logic              o_busy;
    logic [3:0]        o_crd_cnt;
    logic              o_crd_ovf_err;

    assign req_decode = {dec[2], dec[1], dec[0]};
    assign req_data   = {dat[2], dat[1], dat[0]};

    ucie_ctl_sb_arbiter #(
        .NREQ    (NREQ),
        .NC      (32),
        .CRD_MAX (CRD_MAX)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_req_valid   (valid),
        .i_req_decode  (req_decode),
        .i_req_data    (req_data),
        .o_req_ready   (o_req_ready),
        .o_cfg_vld     (o_cfg_vld),
        .o_cfg         (o_cfg),
        .i_cfg_crd     (crd),
        .o_busy        (o_busy),
        .o_crd_cnt     (o_crd_cnt),
        .o_crd_ovf_err (o_crd_ovf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Reference model: beats still owed after the one currently on the bus.
    logic [31:0] beats [$];
    int          m_crd;
    int          m_ptr;
    logic        m_ovf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [31:0] exp_hdr(input logic [4:0] d, input int src);
        logic [30:0] low;
        low = {23'd0, 3'(src), d};
        return {^low, low};
    endfunction

    function automatic int pick();
        if (rst || beats.size() != 0 || m_crd == 0 || valid == '0) return -1;
`ifdef UCIE_SB_ARB_ERR_PRIO_EN
        if (valid[0]) return 0;
`endif
        for (int j = 0; j < NREQ; j++) begin
            int k;
            k = (m_ptr + j) % NREQ;
            if (valid[k]) return k;
        end
        return -1;
    endfunction

    // Called just after a falling edge with inputs already applied.
    task automatic cycle();
        int          g;
        logic [2:0]  exp_rdy;
        logic [31:0] exp_cfg;
        logic        exp_vld;
        #1;
        g       = pick();
        exp_rdy = (g >= 0) ? (3'b001 << g) : 3'b000;
        chk("ready", {29'd0, o_req_ready}, {29'd0, exp_rdy});
        if (rst) begin
            beats.delete();
            m_crd = CRD_MAX;
            m_ptr = 0;
            m_ovf = 1'b0;
        end else begin
            if (g >= 0) begin
                beats.push_back(exp_hdr(dec[g], g));
                if (dec[g][4]) beats.push_back(dat[g]);
`ifdef UCIE_SB_ARB_ERR_PRIO_EN
                if (g != 0) m_ptr = (g + 1) % NREQ;
`else
                m_ptr = (g + 1) % NREQ;
`endif
            end
            if (g >= 0 && !crd) m_crd--;
            else if (g < 0 && crd) begin
                if (m_crd == CRD_MAX) m_ovf = 1'b1;
                else m_crd++;
            end
        end
        @(posedge clk);
        #1;
        if (beats.size() > 0) begin
            exp_cfg = beats.pop_front();
            exp_vld = 1'b1;
        end else begin
            exp_cfg = '0;
            exp_vld = 1'b0;
        end
        chk("cfg_vld", {31'd0, o_cfg_vld}, {31'd0, exp_vld});
        chk("cfg", o_cfg, exp_cfg);
        chk("busy", {31'd0, o_busy}, {31'd0, exp_vld});
        chk("crd_cnt", {28'd0, o_crd_cnt}, 32'(m_crd));
        chk("ovf", {31'd0, o_crd_ovf_err}, {31'd0, m_ovf});
        @(negedge clk);
    endtask

    logic [2:0] order [4];

    initial begin
        order = '{3'b001, 3'b010, 3'b100, 3'b001};
        rst   = 1'b1;
        valid = '0;
        crd   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            dec[k] = '0;
            dat[k] = '0;
        end
        m_crd = CRD_MAX;
        m_ptr = 0;
        m_ovf = 1'b0;
        @(posedge clk);
        @(negedge clk);

        // Reset state with requests pending
        valid = 3'b111;
        cycle();
        chk("rst_ready", {29'd0, o_req_ready}, 32'd0);
        chk("rst_crd", {28'd0, o_crd_cnt}, 32'd4);
        rst   = 1'b0;
        valid = '0;
        cycle();

        // Header-only from requester 1
        valid  = 3'b010;
        dec[1] = 5'h03;
        #1;
        chk("B_ready", {29'd0, o_req_ready}, 32'h2);
        cycle();
        chk("B_hdr", o_cfg, 32'h8000_0023);
        chk("B_crd", {28'd0, o_crd_cnt}, 32'd3);
        valid = '0;
        cycle();

        // Payload message from requester 2
        valid  = 3'b100;
        dec[2] = 5'h11;
        dat[2] = 32'hDEAD_BEEF;
        cycle();
        chk("C_hdr_lo", {24'd0, o_cfg[7:0]}, 32'h51);
        valid = '0;
        cycle();
        chk("C_payload", o_cfg, 32'hDEAD_BEEF);
        chk("C_busy2", {31'd0, o_busy}, 32'd1);
        cycle();
        chk("C_idle", {31'd0, o_busy}, 32'd0);

        // Round-robin with three header-only requesters and credit exhaustion
        rst = 1'b1;
        cycle();
        rst    = 1'b0;
        dec[0] = 5'h01;
        dec[1] = 5'h02;
        dec[2] = 5'h0F;
        valid  = 3'b111;
        for (int i = 0; i < 4; i++) begin
`ifndef UCIE_SB_ARB_ERR_PRIO_EN
            #1;
            chk("D_order", {29'd0, o_req_ready}, {29'd0, order[i]});
`endif
            cycle();
        end
        #1;
        chk("D_nocrd_rdy", {29'd0, o_req_ready}, 32'd0);
        chk("D_crd0", {28'd0, o_crd_cnt}, 32'd0);
        cycle();
        crd = 1'b1;
        cycle();
        crd = 1'b0;
`ifndef UCIE_SB_ARB_ERR_PRIO_EN
        #1;
        chk("D_crd_grant", {29'd0, o_req_ready}, 32'h2);
`endif
        cycle();
        #1;
        chk("D_one_only", {29'd0, o_req_ready}, 32'd0);
        cycle();

        // Accept and credit return in the same cycle
        valid = '0;
        crd   = 1'b1;
        cycle();
        valid = 3'b111;
        cycle();
        chk("E_simul", {28'd0, o_crd_cnt}, 32'd1);
        valid = '0;
        crd   = 1'b0;
        cycle();

        // Credit overflow is sticky until reset
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        crd = 1'b1;
        cycle();
        chk("F_ovf", {31'd0, o_crd_ovf_err}, 32'd1);
        chk("F_crd_hold", {28'd0, o_crd_cnt}, 32'd4);
        crd = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        chk("F_sticky", {31'd0, o_crd_ovf_err}, 32'd1);
        rst = 1'b1;
        cycle();
        chk("F_clear", {31'd0, o_crd_ovf_err}, 32'd0);
        rst = 1'b0;

        // Reset during the payload beat
        valid  = 3'b001;
        dec[0] = 5'h15;
        dat[0] = 32'h1234_5678;
        cycle();
        valid = '0;
        cycle();
        chk("G_data", o_cfg, 32'h1234_5678);
        rst = 1'b1;
        cycle();
        chk("G_vld", {31'd0, o_cfg_vld}, 32'd0);
        chk("G_crd", {28'd0, o_crd_cnt}, 32'd4);
        chk("G_idle", {31'd0, o_busy}, 32'd0);
        rst = 1'b0;
        cycle();
        chk("G_no_partial", {31'd0, o_cfg_vld}, 32'd0);

`ifdef UCIE_SB_ARB_ERR_PRIO_EN
        // Error source wins every cycle while valid
        dec[0] = 5'h01;
        dec[1] = 5'h02;
        valid  = 3'b011;
        crd    = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("P_prio", {29'd0, o_req_ready}, 32'h1);
            cycle();
        end
        valid = '0;
        crd   = 1'b0;
        cycle();
`endif

        // Randomized traffic, credit returns and occasional reset
        for (int i = 0; i < 400; i++) begin
            valid = 3'($urandom_range(0, 7));
            for (int k = 0; k < NREQ; k++) begin
                dec[k] = 5'($urandom);
                dat[k] = $urandom;
            end
            crd = ($urandom_range(0, 2) == 0);
            rst = ($urandom_range(0, 99) == 0);
            cycle();
        end
        rst   = 1'b0;
        valid = '0;
        crd   = 1'b0;
        cycle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ucie_ctl_sb_arbiter.md
# ucie_ctl_sb_arbiter

Credit-controlled arbiter that shares the single RDI sideband transmit channel between sideband message sources. Sources include the CNTL link-state and error messages, the CSR-originated capability messages, and a spare source. It grants one requester at a time, formats the message into NC-bit header and optional payload beats, and throttles issue against the sideband credits returned by the physical layer. It sits between the CNTL/CSR sideband request wires and the sideband TX serializer inside UCIE_ctl_sb_top.

## Interface
- NREQ, 3, number of requesters; legal range 2..8; requester 0 is the error source
- NC, 32, sideband beat width; only 32 is legal
- CRD_MAX, 4, credits available after reset; legal range 1..15
- i_clk  in  1  clock
- i_rst  in  1  synchronous, active-high reset
- i_req_valid  in  NREQ  per-requester message valid; held until accepted
- i_req_decode  in  5*NREQ  per-requester message decode; requester k uses bits [5k+4:5k]
- i_req_data  in  32*NREQ  per-requester payload; requester k uses bits [32k+31:32k]
- o_req_ready  out  NREQ  one-hot grant; a transfer occurs when valid and ready are both high
- o_cfg_vld  out  1  sideband beat valid
- o_cfg  out  NC  sideband beat data
- i_cfg_crd  in  1  single-cycle pulse; returns one credit
- o_busy  out  1  high when the state is not IDLE
- o_crd_cnt  out  4  current credit count
- o_crd_ovf_err  out  1  sticky flag: a credit was returned while the count was already CRD_MAX

## Operation
- FSM states:
  - IDLE: waiting for a request.
  - HDR: sending the header beat.
  - DATA: sending the payload beat.
- Grant eligibility:
  - A grant is possible in IDLE, or in the final beat of the current message: HDR for a header-only message, DATA otherwise.
  - Eligibility also requires o_crd_cnt > 0 and at least one valid requester.
  - o_req_ready is combinational and is never high when no grant is possible.
- Arbitration is round-robin:
  - The search starts at pointer p.
  - After a grant to requester k, p is set to (k+1) mod NREQ.
  - p resets to 0.
- On accept:
  - The requester index, decode and data are latched.
  - The next state is HDR.
- Header beat:
  - o_cfg[4:0] = decode.
  - o_cfg[7:5] = requester index.
  - o_cfg[30:8] = 0.
  - o_cfg[31] = even parity over o_cfg[30:0].
- Payload:
  - A payload beat is sent only when decode[4] = 1.
  - In that case HDR goes to DATA and o_cfg = latched data.
- After the final beat:
  - If a new grant occurs in that cycle, the next state is HDR.
  - Otherwise the next state is IDLE.
- Credit counter:
  - Resets to CRD_MAX.
  - Accept alone: count − 1.
  - i_cfg_crd alone: count + 1.
  - Accept and i_cfg_crd in the same cycle: count unchanged.
  - i_cfg_crd while count = CRD_MAX (with no accept in that cycle): count is held at CRD_MAX and o_crd_ovf_err is set.
- o_crd_ovf_err is cleared only by i_rst.
- A requester that drops valid before it is granted is not served. This is legal and is not an error.

## Timing
- Reset values:
  - o_cfg_vld = 0, o_cfg = 0.
  - o_req_ready = 0 while i_rst is high.
  - o_busy = 0, o_crd_cnt = CRD_MAX, o_crd_ovf_err = 0.
  - State = IDLE, p = 0.
- Accept in cycle T:
  - Header on o_cfg at T+1.
  - Payload, if present, at T+2.
- Sustained throughput:
  - Header-only messages: one per cycle.
  - Payload messages: one per two cycles.
  - Both are bounded by available credits.
- o_cfg_vld is high exactly during HDR and DATA.
- o_cfg is 0 whenever o_cfg_vld = 0.
- o_crd_cnt updates in the cycle after the accept or credit event.
- A credit returned at T is usable for a grant at T+1.
- Reset asserted mid-message aborts the message:
  - o_cfg_vld = 0 in the cycle after i_rst is sampled high.
  - No partial payload beat is sent.

## Configuration
- Macro UCIE_SB_ARB_ERR_PRIO_EN.
- When defined:
  - Requester 0 wins over the round-robin order whenever it is valid.
  - Granting requester 0 does not advance p.
- When undefined:
  - Pure round-robin; requester 0 has no special priority.

## Structure
- Package ucie_ctl_sb_arb_pkg contains:
  - the state enum (IDLE, HDR, DATA);
  - the header field positions: DEC_LSB = 0, SRC_LSB = 5, PAR_BIT = 31;
  - the payload flag bit index, 4;
  - the credit counter width, 4.
- Sub-module ucie_ctl_rr_arbiter:
  - Inputs: request vector, pointer, enable.
  - Output: one-hot grant.
  - Instantiated once.

## Test plan
- Reset, then requester 1 sends decode 5'h03 (header only):
  - Ready high in the valid cycle.
  - At T+1: o_cfg = 32'h8000_0023 (parity bit 1) with o_cfg_vld = 1.
  - o_crd_cnt = 3.
- Requester 2 sends decode 5'h11 with data 32'hDEAD_BEEF:
  - Header o_cfg[7:0] = 8'h51 at T+1.
  - Payload 32'hDEAD_BEEF at T+2.
  - o_busy high for 2 cycles.
- All three requesters held valid with header-only messages and 4 credits:
  - Grant order 0, 1, 2, 0.
  - No further grants once o_crd_cnt = 0.
  - One i_cfg_crd pulse produces exactly one further grant, the next cycle.
- Simultaneous accept and i_cfg_crd: o_crd_cnt unchanged.
- i_cfg_crd at count 4: count stays 4 and o_crd_ovf_err stays 1 until reset.
- With UCIE_SB_ARB_ERR_PRIO_EN defined and requesters 0 and 1 continuously valid:
  - Requester 0 is granted every cycle.
- Reset asserted during DATA: o_cfg_vld = 0 at the next cycle, o_crd_cnt = 4, state IDLE.
